// File: rtl/config_master_if.sv
// config_master_if: AHB master-side signal bundle for config_master.
// Width follows BUSWIDTH of the master it connects to.
interface config_master_if #(
    parameter int BUSWIDTH = 32
);
    logic                ahb_hgrant;
    logic                ahb_hready;
    logic                ahb_hresp;
    logic                ahb_hbusreq;
    logic                ahb_hlock;
    logic                ahb_hwrite;
    logic [1:0]          ahb_htrans;
    logic [2:0]          ahb_hburst;
    logic [BUSWIDTH-1:0] ahb_haddr;
    logic [BUSWIDTH-1:0] ahb_hwdata;

    modport master (
        input  ahb_hgrant, ahb_hready, ahb_hresp,
        output ahb_hbusreq, ahb_hlock, ahb_hwrite,
        output ahb_htrans, ahb_hburst, ahb_haddr, ahb_hwdata
    );

    modport slave (
        output ahb_hgrant, ahb_hready, ahb_hresp,
        input  ahb_hbusreq, ahb_hlock, ahb_hwrite,
        input  ahb_htrans, ahb_hburst, ahb_haddr, ahb_hwdata
    );
endinterface

// File: rtl/config_master.sv
// config_master: locked AHB master writing five configuration words to one slave.
// Define CONFIG_MASTER_RETRY_EN to retry errored words up to MAX_RETRY times.
module config_master #(
    parameter int BUSWIDTH     = 32,
    parameter int SLAVEADDRESS = 3337,
    parameter int MAX_RETRY    = 3
) (
    input  logic                ahb_hclk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [BUSWIDTH-1:0] cfg_width,
    input  logic [BUSWIDTH-1:0] cfg_height,
    input  logic [BUSWIDTH-1:0] cfg_read_start,
    input  logic [BUSWIDTH-1:0] cfg_write_start,
    input  logic                cfg_filter,
    output logic                busy,
    output logic                done,
    output logic                error,
    config_master_if.master     ahb
);
    typedef enum logic [2:0] {
        IDLE, REQ, ADDR, DATA, DONE, ERR
    } state_t;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;

    // A zero limit makes the first error fatal.
`ifdef CONFIG_MASTER_RETRY_EN
    localparam int RETRY_LIM = MAX_RETRY;
`else
    localparam int RETRY_LIM = 0;
`endif
    localparam int RW = $clog2(MAX_RETRY + 2);

    state_t              state;
    state_t              state_n;
    logic [2:0]          idx;
    logic [2:0]          idx_n;
    logic [RW-1:0]       retry;
    logic [RW-1:0]       retry_n;
    logic                load;
    logic [BUSWIDTH-1:0] word_q [5];
    logic [BUSWIDTH-1:0] wsel;

    assign ahb.ahb_hburst = 3'b000;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        retry_n = retry;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = REQ;
                    idx_n   = '0;
                    retry_n = '0;
                    load    = 1'b1;
                end
            end
            REQ: begin
                if (ahb.ahb_hgrant) state_n = ADDR;
            end
            ADDR: begin
                if (ahb.ahb_hready) state_n = DATA;
                else if (!ahb.ahb_hgrant) state_n = REQ;
            end
            DATA: begin
                if (ahb.ahb_hready) begin
                    if (!ahb.ahb_hresp) begin
                        if (idx == 3'd4) begin
                            state_n = DONE;
                        end else begin
                            idx_n   = idx + 3'd1;
                            retry_n = '0;
                            state_n = ADDR;
                        end
                    end else if (retry != RW'(RETRY_LIM)) begin
                        retry_n = retry + RW'(1);
                        state_n = ADDR;
                    end else begin
                        state_n = ERR;
                    end
                end
            end
            DONE:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        case (idx_n)
            3'd0:    wsel = word_q[0];
            3'd1:    wsel = word_q[1];
            3'd2:    wsel = word_q[2];
            3'd3:    wsel = word_q[3];
            default: wsel = word_q[4];
        endcase
    end

    // Outputs are decoded from the next state so they leave a flop.
    always_ff @(posedge ahb_hclk or negedge n_rst) begin
        if (!n_rst) begin
            state           <= IDLE;
            idx             <= '0;
            retry           <= '0;
            for (int i = 0; i < 5; i++) word_q[i] <= '0;
            ahb.ahb_hbusreq <= 1'b0;
            ahb.ahb_hlock   <= 1'b0;
            ahb.ahb_hwrite  <= 1'b0;
            ahb.ahb_htrans  <= HT_IDLE;
            ahb.ahb_haddr   <= '0;
            ahb.ahb_hwdata  <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            retry <= retry_n;
            if (load) begin
                word_q[0] <= cfg_width;
                word_q[1] <= cfg_height;
                word_q[2] <= cfg_read_start;
                word_q[3] <= cfg_write_start;
                word_q[4] <= {{(BUSWIDTH-1){1'b0}}, cfg_filter};
            end
            ahb.ahb_hbusreq <= state_n inside {REQ, ADDR, DATA};
            ahb.ahb_hlock   <= state_n inside {REQ, ADDR, DATA};
            ahb.ahb_hwrite  <= state_n inside {ADDR, DATA};
            ahb.ahb_htrans  <= (state_n == ADDR) ? HT_NONSEQ : HT_IDLE;
            ahb.ahb_haddr   <= (state_n inside {ADDR, DATA}) ?
                               BUSWIDTH'(SLAVEADDRESS) : '0;
            ahb.ahb_hwdata  <= (state_n == DATA) ? wsel : '0;
            busy            <= state_n != IDLE;
            done            <= state_n == DONE;
            if (load) error <= 1'b0;
            else if (state_n == ERR) error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_config_master.sv
// tb_config_master: random and directed scoreboard bench for config_master.
// Expected writes/outcomes come from a word-level model of the sequence.
module tb_config_master;
    localparam int BW  = 32;
    localparam int SLV = 3337;
`ifdef CONFIG_MASTER_RETRY_EN
    localparam int LIM = 3;
`else
    localparam int LIM = 0;
`endif

    logic          clk = 1'b0;
    logic          n_rst;
    logic          start;
    logic [BW-1:0] cfg_width;
    logic [BW-1:0] cfg_height;
    logic [BW-1:0] cfg_read_start;
    logic [BW-1:0] cfg_write_start;
    logic          cfg_filter;
    logic          busy;
    logic          done;
    logic          error;

    config_master_if #(.BUSWIDTH(BW)) bus ();

    config_master #(
        .BUSWIDTH(BW), .SLAVEADDRESS(SLV), .MAX_RETRY(3)
    ) dut (
        .ahb_hclk(clk),
        .n_rst(n_rst),
        .start(start),
        .cfg_width(cfg_width),
        .cfg_height(cfg_height),
        .cfg_read_start(cfg_read_start),
        .cfg_write_start(cfg_write_start),
        .cfg_filter(cfg_filter),
        .busy(busy),
        .done(done),
        .error(error),
        .ahb(bus.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    logic [BW-1:0] exp_q[$];
    bit            resp_q[$];
    byte           out_q[$];
    int            start_cyc = 0;
    int            exp_lat = -1;
    bit            rand_bus = 1'b0;
    bit            busy_pulse = 1'b0;
    bit            err_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event not expected by model", name);
    endtask

    // Word-level model: each word is retried until it succeeds or
    // its error count exceeds the retry limit.
    function automatic void model(input logic [BW-1:0] wd [5],
                                  input int plan [5]);
        for (int w = 0; w < 5; w++) begin
            if (plan[w] > LIM) begin
                for (int k = 0; k <= LIM; k++) begin
                    exp_q.push_back(wd[w]);
                    resp_q.push_back(1'b1);
                end
                out_q.push_back(8'sd2);
                return;
            end
            for (int k = 0; k < plan[w]; k++) begin
                exp_q.push_back(wd[w]);
                resp_q.push_back(1'b1);
            end
            exp_q.push_back(wd[w]);
            resp_q.push_back(1'b0);
        end
        out_q.push_back(8'sd1);
    endfunction

    task automatic tick();
        if (n_rst && bus.ahb_hwrite && bus.ahb_htrans == 2'b00) begin
            bus.ahb_hresp = (resp_q.size() != 0) ? resp_q[0] : 1'b0;
            if (bus.ahb_hready && resp_q.size() != 0)
                void'(resp_q.pop_front());
        end else begin
            bus.ahb_hresp = 1'b0;
        end
        @(negedge clk);
        if (!start) begin
            cfg_width       = $urandom;
            cfg_height      = $urandom;
            cfg_read_start  = $urandom;
            cfg_write_start = $urandom;
            cfg_filter      = 1'($urandom);
        end
        if (rand_bus) begin
            bus.ahb_hgrant = $urandom_range(3) != 0;
            bus.ahb_hready = $urandom_range(2) != 0;
        end
        if (busy_pulse) start = busy && ($urandom_range(5) == 0);
    endtask

    task automatic send(input logic [BW-1:0] wd [5], input int plan [5]);
        cfg_width       = wd[0];
        cfg_height      = wd[1];
        cfg_read_start  = wd[2];
        cfg_write_start = wd[3];
        cfg_filter      = wd[4][0];
        start     = 1'b1;
        start_cyc = cyc;
        model(wd, plan);
        tick();
        start = 1'b0;
        chk("start_accept", {busy, error}, 2'b10);
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (busy && n < max) begin
            tick();
            n++;
        end
        if (busy) flag_fail("timeout_busy");
    endtask

    always @(negedge clk) begin
        #1;
        if (!n_rst) begin
            chk("rst_ctrl", {bus.ahb_hbusreq, bus.ahb_hlock,
                bus.ahb_hwrite, bus.ahb_htrans, bus.ahb_hburst,
                busy, done, error}, 64'd0);
            chk("rst_haddr", bus.ahb_haddr, 64'd0);
            chk("rst_hwdata", bus.ahb_hwdata, 64'd0);
        end else begin
            if (bus.ahb_hwrite && bus.ahb_htrans == 2'b00 &&
                bus.ahb_hready) begin
                if (exp_q.size() == 0) begin
                    flag_fail("unexpected_write");
                end else begin
                    chk("write_data", bus.ahb_hwdata, exp_q.pop_front());
                    chk("write_addr", bus.ahb_haddr, SLV);
                end
            end
            if (done) begin
                if (out_q.size() == 0) begin
                    flag_fail("unexpected_done");
                end else begin
                    chk("outcome_done", out_q.pop_front(), 64'd1);
                    if (exp_lat >= 0)
                        chk("latency", cyc - start_cyc, exp_lat);
                end
            end
            if (error && !err_prev) begin
                if (out_q.size() == 0) flag_fail("unexpected_error");
                else chk("outcome_error", out_q.pop_front(), 64'd2);
            end
        end
        err_prev = error;
    end

    initial begin
        logic [BW-1:0] wd [5];
        int            plan [5];
        n_rst = 1'b0;
        start = 1'b0;
        cfg_width = '0;
        cfg_height = '0;
        cfg_read_start = '0;
        cfg_write_start = '0;
        cfg_filter = 1'b0;
        bus.ahb_hgrant = 1'b0;
        bus.ahb_hready = 1'b0;
        bus.ahb_hresp  = 1'b0;
        repeat (3) tick();
        n_rst = 1'b1;
        bus.ahb_hgrant = 1'b1;
        bus.ahb_hready = 1'b1;
        tick();

        wd   = '{640, 480, 32'h1000, 32'h8000, 1};
        plan = '{default: 0};
        exp_lat = 12;
        send(wd, plan);
        wait_idle(100);

        exp_lat = 16;
        bus.ahb_hgrant = 1'b0;
        send(wd, plan);
        for (int i = 0; i < 4; i++) begin
            chk("grant_wait", {bus.ahb_hbusreq, bus.ahb_hlock,
                bus.ahb_htrans}, 4'b1100);
            tick();
        end
        bus.ahb_hgrant = 1'b1;
        wait_idle(100);

        exp_lat = 14;
        send(wd, plan);
        while (cyc < start_cyc + 7) tick();
        bus.ahb_hready = 1'b0;
        chk("hold_wdata0", bus.ahb_hwdata, 32'h1000);
        tick();
        chk("hold_wdata1", bus.ahb_hwdata, 32'h1000);
        tick();
        bus.ahb_hready = 1'b1;
        chk("hold_wdata2", bus.ahb_hwdata, 32'h1000);
        wait_idle(100);

        exp_lat = -1;
        plan = '{0, 1, 0, 0, 0};
        send(wd, plan);
        wait_idle(100);
        plan = '{0, 4, 0, 0, 0};
        send(wd, plan);
        wait_idle(100);
        plan = '{default: 0};

        exp_lat = 12;
        send(wd, plan);
        while (cyc < start_cyc + 9) tick();
        n_rst = 1'b0;
        exp_q.delete();
        resp_q.delete();
        out_q.delete();
        tick();
        tick();
        n_rst = 1'b1;
        tick();
        send(wd, plan);
        wait_idle(100);

        exp_lat = -1;
        busy_pulse = 1'b1;
        send(wd, plan);
        wait_idle(100);

        rand_bus = 1'b1;
        repeat (40) begin
            for (int i = 0; i < 4; i++) wd[i] = $urandom;
            wd[4] = BW'($urandom_range(1));
            for (int i = 0; i < 5; i++)
                plan[i] = ($urandom_range(9) == 0) ?
                          int'($urandom_range(4, 1)) : 0;
            send(wd, plan);
            wait_idle(2000);
            tick();
        end
        rand_bus = 1'b0;
        busy_pulse = 1'b0;
        bus.ahb_hgrant = 1'b1;
        bus.ahb_hready = 1'b1;
        repeat (4) tick();
        chk("leftover_writes", exp_q.size(), 64'd0);
        chk("leftover_outcomes", out_q.size(), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/config_master.md
CONFIG_MASTER -- requirements
Module: config_master

Interface
REQ-001 SHALL have parameter BUSWIDTH, default 32, data/address bus width.
REQ-002 SHALL have parameter SLAVEADDRESS, default 3337, target address of the configuration slave.
REQ-003 SHALL have parameter MAX_RETRY, default 3, error retries per word.
REQ-004 ahb_hclk  in  1  bus clock, rising edge; one clock only.
REQ-005 n_rst  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle request to send a configuration sequence.
REQ-007 cfg_width, cfg_height, cfg_read_start, cfg_write_start  in  BUSWIDTH each  configuration words.
REQ-008 cfg_filter  in  1  filter type; sent zero-extended to BUSWIDTH.
REQ-009 ahb_hgrant / ahb_hready / ahb_hresp  in  1 each  grant; slave ready; response (1 = error).
REQ-010 ahb_hbusreq / ahb_hlock / ahb_hwrite  out  1 each  bus request; locked sequence; write direction.
REQ-011 ahb_htrans  out  2  IDLE=2'b00, NONSEQ=2'b10; ahb_hburst  out  3  always 3'b000 (SINGLE).
REQ-012 ahb_haddr / ahb_hwdata  out  BUSWIDTH each  address; write data.
REQ-013 busy  out  1  sequence in progress; done  out  1  one-cycle success pulse; error  out  1  sticky failure flag.

Function
REQ-014 SHALL capture all cfg_* inputs on the cycle start is sampled high in IDLE; later changes SHALL NOT affect the sequence.
REQ-015 SHALL ignore start while busy=1.
REQ-016 FSM states SHALL be IDLE, REQ, ADDR, DATA, DONE, ERR.
REQ-017 IDLE->REQ on start; REQ asserts ahb_hbusreq and ahb_hlock, stays until ahb_hgrant=1, then ->ADDR.
REQ-018 ADDR SHALL drive ahb_htrans=NONSEQ, ahb_haddr=SLAVEADDRESS, ahb_hwrite=1; ->DATA on the first cycle ahb_hready=1, else hold all address-phase signals.
REQ-019 DATA SHALL drive ahb_htrans=IDLE and ahb_hwdata=word[idx], idx order 0..4 = width, height, read start, write start, filter; ahb_hwdata SHALL be stable until ahb_hready=1.
REQ-020 In DATA with ahb_hready=1, ahb_hresp=0: idx<4 -> idx+1, retry count cleared, ->ADDR; idx=4 -> DONE.
REQ-021 In DATA with ahb_hready=1, ahb_hresp=1: retry count<MAX_RETRY -> count+1, ->ADDR with same idx; else ->ERR.
REQ-022 If ahb_hgrant falls while in ADDR before ahb_hready=1, SHALL return to REQ keeping idx and retry count.
REQ-023 DONE SHALL pulse done=1 for exactly one cycle, deassert ahb_hbusreq/ahb_hlock, ->IDLE.
REQ-024 ERR SHALL set error=1, deassert ahb_hbusreq/ahb_hlock, ->IDLE; error SHALL clear on the next accepted start.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 Minimum latency, start to done, with grant and ready always high: 12 cycles (1 REQ + 5x(ADDR+DATA) + DONE).
REQ-027 Outside ADDR, ahb_htrans SHALL be IDLE; ahb_hwrite SHALL be 0 outside ADDR/DATA.

Reset
REQ-028 n_rst low SHALL force IDLE immediately, idx=0, retry count=0, all outputs 0 (ahb_htrans=IDLE, ahb_haddr=0, ahb_hwdata=0, busy=done=error=0).
REQ-029 Reset mid-sequence SHALL abandon the sequence with no done or error; the next start SHALL send all five words from idx 0.

Configuration
REQ-030 Macro CONFIG_MASTER_RETRY_EN defined: retry behaviour per REQ-021.
REQ-031 Macro CONFIG_MASTER_RETRY_EN undefined: any ahb_hresp=1 in DATA with ahb_hready=1 SHALL go directly to ERR; MAX_RETRY SHALL be unused.

Verification
REQ-032 Grant/ready high, start with width=640, height=480, read 0x1000, write 0x8000, filter=1 -> five writes to 3337 with data 640,480,0x1000,0x8000,1; done at cycle 12.
REQ-033 ahb_hgrant low 4 cycles after start -> ahb_hbusreq held, no NONSEQ until grant; done at cycle 16.
REQ-034 ahb_hready low 2 cycles in DATA of word 2 -> ahb_hwdata held at 0x1000 throughout; sequence completes.
REQ-035 (RETRY_EN) ahb_hresp=1 once on word 1 -> word 1 (480) re-sent, done asserted; ahb_hresp=1 on 4 consecutive attempts -> error=1, no done.
REQ-036 n_rst low during DATA of word 3, then start -> outputs zero during reset; new sequence begins with width word.
REQ-037 start pulsed while busy -> ignored; exactly five writes observed.
